// File: rtl/gf256_tower_inverter_if.sv
// ============================================================================
// Module      : gf256_tower_inverter_if
// Description : Valid/ready byte-in / byte-out bundle for the tower inverter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gf256_tower_inverter_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/gf256_tower_inverter.sv
// ============================================================================
// Module      : gf256_tower_inverter
// Description : Sequential GF((2^4)^2) inverter, one shared GF(2^4) multiplier,
//               11 steps per byte. Option macro: GF256_INV_ZERO_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf256_tower_inverter #(
  parameter logic [3:0] LAMBDA = 4'hE
) (
  input wire                      clk,
  input wire                      rst_n,
  gf256_tower_inverter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_LAST_STEP = 4'd10;

  // GF(2^4) product modulo x^4 + x + 1 (FFMul_K4_Q2), evaluated at one site only.
  function automatic logic [3:0] ffmul_k4_q2(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] w_p;
    logic [3:0] w_x;
    w_p = 4'h0;
    w_x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) w_p = w_p ^ w_x;
      w_x = w_x[3] ? ({w_x[2:0], 1'b0} ^ 4'b0011) : {w_x[2:0], 1'b0};
    end
    return w_p;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_step;
  logic [3:0] r_ah;
  logic [3:0] r_al;
  logic [3:0] r_acc;
  logic [3:0] r_delta;
  logic [3:0] r_bh;
  logic [7:0] r_out_data;
  logic [3:0] w_opa;
  logic [3:0] w_opb;
  logic [3:0] w_prod;
  logic       w_accept;
  logic       w_bypass;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

`ifdef GF256_INV_ZERO_BYPASS_EN
  assign w_bypass = (bus.in_data == 8'h00);
`else
  assign w_bypass = 1'b0;
`endif

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_data  = r_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_CALC;
      S_CALC:  if (r_step == c_LAST_STEP) w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand selection for the single shared multiplier, indexed by step-1.
  always_comb begin
    w_opa = 4'h0;
    w_opb = 4'h0;
    case (r_step)
      4'd0:    begin w_opa = r_ah;        w_opb = r_ah;    end
      4'd1:    begin w_opa = r_acc;       w_opb = LAMBDA;  end
      4'd2:    begin w_opa = r_ah;        w_opb = r_al;    end
      4'd3:    begin w_opa = r_al;        w_opb = r_al;    end
      4'd4:    begin w_opa = r_delta;     w_opb = r_delta; end
      4'd5:    begin w_opa = r_acc;       w_opb = r_delta; end
      4'd6:    begin w_opa = r_acc;       w_opb = r_acc;   end
      4'd7:    begin w_opa = r_acc;       w_opb = r_delta; end
      4'd8:    begin w_opa = r_acc;       w_opb = r_acc;   end
      4'd9:    begin w_opa = r_ah;        w_opb = r_acc;   end
      4'd10:   begin w_opa = r_ah ^ r_al; w_opb = r_acc;   end
      default: begin w_opa = 4'h0;        w_opb = 4'h0;    end
    endcase
  end

  assign w_prod = ffmul_k4_q2(w_opa, w_opb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step     <= 4'd0;
      r_ah       <= 4'h0;
      r_al       <= 4'h0;
      r_acc      <= 4'h0;
      r_delta    <= 4'h0;
      r_bh       <= 4'h0;
      r_out_data <= 8'h00;
    end else if (w_accept) begin
      r_ah <= bus.in_data[7:4];
      r_al <= bus.in_data[3:0];
      r_bh <= 4'h0;
      // A bypassed zero runs only the final step: (ah^al)=0 and bh=0 give 8'h00.
      r_step <= w_bypass ? c_LAST_STEP : 4'd0;
    end else if (r_state == S_CALC) begin
      r_step <= r_step + 4'd1;
      case (r_step)
        4'd2:    r_acc      <= r_acc ^ w_prod;
        4'd3:    r_delta    <= r_acc ^ w_prod;
        4'd9:    r_bh       <= w_prod;
        4'd10:   r_out_data <= {r_bh, w_prod};
        default: r_acc      <= w_prod;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gf256_tower_inverter.sv
// ============================================================================
// Module      : tb_gf256_tower_inverter
// Description : Self-checking bench: directed tests plus random bytes against
//               a brute-force GF((2^4)^2) inverse model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf256_tower_inverter;

  localparam logic [3:0] c_LAMBDA = 4'hE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   lit_exp     = -1;

  gf256_tower_inverter_if bus ();

  gf256_tower_inverter #(.LAMBDA(c_LAMBDA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Polynomial multiply then reduce by x^4+x+1.
  function automatic logic [3:0] m_mul16(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = 7'd0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'b0010011 << (i - 4));
    return p[3:0];
  endfunction

  // (ah*y+al)(bh*y+bl) with y^2 = y + lambda.
  function automatic logic [7:0] m_mul256(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    logic [3:0] hi;
    logic [3:0] lo;
    hh = m_mul16(a[7:4], b[7:4]);
    hi = hh ^ m_mul16(a[7:4], b[3:0]) ^ m_mul16(a[3:0], b[7:4]);
    lo = m_mul16(hh, c_LAMBDA) ^ m_mul16(a[3:0], b[3:0]);
    return {hi, lo};
  endfunction

  function automatic logic [7:0] m_inv(input logic [7:0] a);
    logic [7:0] b;
    if (a == 8'h00) return 8'h00;
    for (int i = 1; i < 256; i++) begin
      b = 8'(i);
      if (m_mul256(a, b) == 8'h01) return b;
    end
    return 8'h00;
  endfunction

  function automatic int m_lat(input logic [7:0] d);
`ifdef GF256_INV_ZERO_BYPASS_EN
    return (d == 8'h00) ? 1 : 11;
`else
    return (d == 8'h00) ? 11 : 11;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference state, advanced from the handshakes observed on the bus.
  logic       m_busy   = 1'b0;
  int         m_acc_edge = 0;
  int         m_lat_cur  = 11;
  logic [7:0] m_exp    = 8'h00;
  logic       acc_pend = 1'b0;
  logic       rel_pend = 1'b0;
  logic [7:0] pend_data = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy   = 1'b0;
      acc_pend = 1'b0;
      rel_pend = 1'b0;
      check("rst_in_ready",  int'(bus.in_ready),  1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_data",  int'(bus.out_data),  0);
    end else begin
      if (rel_pend) m_busy = 1'b0;
      if (acc_pend) begin
        m_busy     = 1'b1;
        m_acc_edge = cyc;
        m_exp      = m_inv(pend_data);
        m_lat_cur  = m_lat(pend_data);
      end
      acc_pend = 1'b0;
      rel_pend = 1'b0;
      check("in_ready", int'(bus.in_ready), int'(!m_busy));
      check("out_valid", int'(bus.out_valid),
            int'(m_busy && ((cyc - m_acc_edge) >= m_lat_cur)));
      if (bus.out_valid) check("out_data", int'(bus.out_data), int'(m_exp));
      if (bus.in_valid && bus.in_ready) begin
        acc_pend  = 1'b1;
        pend_data = bus.in_data;
      end
      if (bus.out_valid && bus.out_ready) begin
        rel_pend = 1'b1;
        if (lit_exp >= 0) check("literal_out", int'(bus.out_data), lit_exp);
      end
    end
  end

  // Returns just after a rising edge with in_ready high; optional noise on
  // in_valid/in_data while busy and random out_ready backpressure.
  task automatic wait_idle(input bit noise, input bit rnd_ready);
    int n;
    n = 0;
    while (n <= 300) begin
      @(posedge clk);
      #1;
      if (bus.in_ready) begin
        bus.in_valid = 1'b0;
        return;
      end
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      if (noise) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 8'($urandom);
      end
      n++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    vectors++;
    miscompares++;
    $display("FAIL wait_idle: actual in_ready=0 required 1 within 300 cycles at cycle %0d", cyc);
  endtask

  task automatic send(input logic [7:0] d, input int lit);
    lit_exp      = lit;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    wait_idle(0, 0); send(8'h01, 8'h01);
    wait_idle(0, 0); send(8'h10, 8'h33);
    wait_idle(0, 0); send(8'h02, 8'h09);
    wait_idle(1, 0); send(8'h00, 8'h00);
    wait_idle(0, 0);

    // Backpressure: result must sit in DONE unchanged.
    bus.out_ready = 1'b0;
    send(8'h10, 8'h33);
    repeat (31) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_idle(0, 0);

    // Reset during step 5 of an in-flight op.
    send(8'h02, -1);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle(0, 0); send(8'h01, 8'h01);
    wait_idle(0, 0);

    for (int i = 0; i < 60; i++) begin
      d = (i % 15 == 0) ? 8'h00 : ((i % 15 == 7) ? 8'hFF : 8'($urandom));
      send(d, -1);
      wait_idle(1, 1);
      bus.out_ready = 1'b1;
    end
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gf256_tower_inverter.md
# gf256_tower_inverter

- Sequential multiplicative inverter for GF(2^8) in tower representation GF((2^4)^2).
- Sits in the SubBytes datapath directly downstream of the basis-change stage and time-shares a single `FFMul_K4_Q2` instance (GF(2^4), x^4+x+1) for every product.
- Accepts one byte per valid/ready transaction, computes the inverse in 11 multiplier steps, and presents the result to the affine stage.
- 0 maps to 0.

## Interface
- `LAMBDA`, default 4'hE — constant λ of the extension polynomial y^2 + y + λ. Bit 3 must be 1 so that the polynomial is irreducible.
- `clk` input 1 — single clock; all state on rising edge.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `in_valid` input 1 — `in_data` is valid.
- `in_ready` output 1 — block can accept; equals (state==IDLE).
- `in_data` input 8 — tower element {ah[7:4], al[3:0]}, meaning ah·y + al.
- `out_valid` output 1 — `out_data` holds the inverse.
- `out_ready` input 1 — consumer accepts `out_data`.
- `out_data` output 8 — inverse {bh, bl}.

## Operation
Math, all in GF(2^4):
- Δ = λ·ah² + ah·al + al².
- Δ⁻¹ = Δ^14.
- bh = ah·Δ⁻¹.
- bl = (ah⊕al)·Δ⁻¹.

FSM states:
- IDLE: `in_ready`=1. On in_valid&in_ready, latch ah/al, clear step counter, go to CALC.
- CALC: one multiplier step per cycle. Operands are muxed to the shared multiplier and the product is registered each cycle. Step sequence:
  - 1: t=ah·ah
  - 2: acc=t·λ
  - 3: acc^=ah·al
  - 4: Δ=acc^(al·al)
  - 5: p=Δ·Δ (Δ²)
  - 6: p=p·Δ (Δ³)
  - 7: p=p·p (Δ⁶)
  - 8: p=p·Δ (Δ⁷)
  - 9: d=p·p (Δ^14)
  - 10: bh=ah·d
  - 11: bl=(ah⊕al)·d
  - After step 11, go to DONE.
- DONE: `out_valid`=1, `out_data` stable. On out_valid&out_ready, go to IDLE.
- `out_data` is held unchanged until the next result is registered.
- `in_valid` is ignored outside IDLE.
- Δ=0 occurs only for input 0. The exponent chain then yields 0 and the output is 0 with no special casing.
- All additions are XOR. The only arithmetic is the 4-bit shared multiplier; no other multipliers are instantiated.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=8'h00, all intermediate registers 0.
- Input accepted at edge N:
  - step k result is registered at edge N+k;
  - `out_valid` rises at edge N+11;
  - latency is 11 cycles.
- Output consumed at edge M (out_valid&out_ready): `out_valid` falls and `in_ready` rises after M. Next accept is no earlier than edge M+1.
- Minimum accept-to-accept spacing is 13 cycles.
- Backpressure: with `out_ready` held low, DONE persists indefinitely and `in_ready` stays 0.
- Async reset mid-CALC or mid-DONE: return immediately to reset values. The in-flight result is discarded and is never presented.

## Configuration
- `GF256_INV_ZERO_BYPASS_EN`
- Defined: an IDLE acceptance with in_data==8'h00 skips CALC and goes straight to DONE with `out_data`=8'h00. `out_valid` rises at edge N+1.
- Undefined: zero follows the full 11-step path, with `out_valid` at edge N+11 and `out_data`=8'h00.
- Nonzero inputs behave identically either way.

## Test plan
- Reset: assert rst_n=0 → `in_ready`=1, `out_valid`=0, `out_data`=8'h00.
- Identity and λ: in 8'h01 → out 8'h01. Then in 8'h10 → out 8'h33 (λ=4'hE). Each has `out_valid` exactly 11 cycles after accept, with out_ready=1.
- Low-nibble element: in 8'h02 → out 8'h09. Check that `in_ready`=0 for the whole CALC/DONE span.
- Backpressure: in 8'h10 with out_ready=0 for 20 cycles → `out_valid`=1 and out_data=8'h33 held stable, `in_ready`=0. Raise out_ready → one transfer, then `in_ready`=1.
- Zero: in 8'h00 → out 8'h00. `out_valid` comes at +1 cycle with `GF256_INV_ZERO_BYPASS_EN` defined, at +11 without it.
- Reset mid-op: accept 8'h02, drop rst_n at step 5 → `out_valid` never asserts for it. After release, in 8'h01 → out 8'h01 at +11.
